// File: rtl/imem_loader.sv
// Streams program words from a valid/ready source into IMEM, pads the remainder with NOPs,
// and holds the CPU in reset until the image is complete.
module imem_loader #(
  parameter int                DEPTH      = 1024,
  parameter int                ADDR_W     = 10,
  parameter int                DATA_W     = 32,
  parameter bit                FILL_NOP   = 1'b1,
  parameter logic [DATA_W-1:0] NOP_WORD   = 'h00000013,
  parameter int                RESET_HOLD = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [DATA_W-1:0] imem_wdata,
  output logic              cpu_reset,
  output logic              load_done,
  output logic [ADDR_W:0]   word_count,
  output logic              truncated
);

  localparam int                HOLD_W    = (RESET_HOLD > 1) ? $clog2(RESET_HOLD) : 1;
  localparam logic [ADDR_W:0]   DEPTH_C   = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]   CAP_C     = (ADDR_W+1)'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RESET_HOLD - 1);

  typedef enum logic [1:0] {LOAD, FILL, HOLD, RUN} state_t;

  state_t              state, state_n;
  logic                in_ready_n, imem_we_n, cpu_reset_n, load_done_n, truncated_n;
  logic [ADDR_W-1:0]   imem_addr_n, fill_ptr, fill_ptr_n;
  logic [DATA_W-1:0]   imem_wdata_n;
  logic [ADDR_W:0]     word_count_n, wc_inc;
  logic [HOLD_W-1:0]   hold_cnt, hold_cnt_n;
  logic                at_cap, xfer;

  assign wc_inc = word_count + 1'b1;
  assign at_cap = (word_count == CAP_C);
  assign xfer   = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= LOAD;
      in_ready   <= 1'b0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      cpu_reset  <= 1'b1;
      load_done  <= 1'b0;
      word_count <= '0;
      truncated  <= 1'b0;
      fill_ptr   <= '0;
      hold_cnt   <= '0;
    end else begin
      state      <= state_n;
      in_ready   <= in_ready_n;
      imem_we    <= imem_we_n;
      imem_addr  <= imem_addr_n;
      imem_wdata <= imem_wdata_n;
      cpu_reset  <= cpu_reset_n;
      load_done  <= load_done_n;
      word_count <= word_count_n;
      truncated  <= truncated_n;
      fill_ptr   <= fill_ptr_n;
      hold_cnt   <= hold_cnt_n;
    end
  end

  // All outputs are registered: this block computes their next values.
  always_comb begin
    state_n      = state;
    in_ready_n   = in_ready;
    imem_we_n    = 1'b0;
    imem_addr_n  = imem_addr;
    imem_wdata_n = imem_wdata;
    cpu_reset_n  = cpu_reset;
    load_done_n  = load_done;
    word_count_n = word_count;
    truncated_n  = truncated;
    fill_ptr_n   = fill_ptr;
    hold_cnt_n   = hold_cnt;

    case (state)
      LOAD: begin
        cpu_reset_n = 1'b1;
        load_done_n = 1'b0;
        hold_cnt_n  = '0;
        in_ready_n  = 1'b1;
        if (xfer) begin
          imem_we_n    = 1'b1;
          imem_addr_n  = word_count[ADDR_W-1:0];
          imem_wdata_n = in_data;
          word_count_n = (word_count == DEPTH_C) ? word_count : wc_inc;
          fill_ptr_n   = wc_inc[ADDR_W-1:0];
          // The DEPTH-th word ends the load even without in_last; memory is full.
          if (in_last || at_cap) begin
            in_ready_n  = 1'b0;
            truncated_n = !in_last && at_cap;
            state_n     = (FILL_NOP && !at_cap) ? FILL : HOLD;
          end
        end
      end
      FILL: begin
        in_ready_n   = 1'b0;
        imem_we_n    = 1'b1;
        imem_addr_n  = fill_ptr;
        imem_wdata_n = NOP_WORD;
        fill_ptr_n   = fill_ptr + 1'b1;
        if (fill_ptr == LAST_ADDR) state_n = HOLD;
      end
      HOLD: begin
        in_ready_n  = 1'b0;
        cpu_reset_n = 1'b1;
        if (hold_cnt == HOLD_LAST) begin
          state_n     = RUN;
          cpu_reset_n = 1'b0;
          load_done_n = 1'b1;
        end else begin
          hold_cnt_n = hold_cnt + 1'b1;
        end
      end
      RUN: begin
        in_ready_n = 1'b0;
        if (start) begin
          state_n      = LOAD;
          in_ready_n   = 1'b1;
          cpu_reset_n  = 1'b1;
          load_done_n  = 1'b0;
          word_count_n = '0;
          truncated_n  = 1'b0;
        end
      end
      default: state_n = LOAD;
    endcase
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench: one loader without padding (DEPTH=1024) and one small padded loader (DEPTH=8),
// sharing stimulus and selected by 'sel'.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        reset, startp, valid, last, sel;
  logic [31:0] data;
  int          total = 0;
  int          bad   = 0;

  logic        ready_a, we_a, cpur_a, done_a, trunc_a;
  logic [9:0]  addr_a;
  logic [31:0] wdata_a;
  logic [10:0] count_a;
  logic        ready_b, we_b, cpur_b, done_b, trunc_b;
  logic [2:0]  addr_b;
  logic [31:0] wdata_b;
  logic [3:0]  count_b;

  logic        o_ready, o_we, o_cpur, o_done, o_trunc;
  logic [9:0]  o_addr;
  logic [31:0] o_wdata;
  logic [10:0] o_count;

  always #5 clk = ~clk;

  imem_loader #(.DEPTH(1024), .ADDR_W(10), .DATA_W(32), .FILL_NOP(1'b0),
                .NOP_WORD(32'h00000013), .RESET_HOLD(2)) dut_a (
    .clk(clk), .reset(reset), .start(startp & ~sel), .in_valid(valid & ~sel),
    .in_ready(ready_a), .in_data(data), .in_last(last), .imem_we(we_a),
    .imem_addr(addr_a), .imem_wdata(wdata_a), .cpu_reset(cpur_a),
    .load_done(done_a), .word_count(count_a), .truncated(trunc_a));

  imem_loader #(.DEPTH(8), .ADDR_W(3), .DATA_W(32), .FILL_NOP(1'b1),
                .NOP_WORD(32'h00000013), .RESET_HOLD(2)) dut_b (
    .clk(clk), .reset(reset), .start(startp & sel), .in_valid(valid & sel),
    .in_ready(ready_b), .in_data(data), .in_last(last), .imem_we(we_b),
    .imem_addr(addr_b), .imem_wdata(wdata_b), .cpu_reset(cpur_b),
    .load_done(done_b), .word_count(count_b), .truncated(trunc_b));

  assign o_ready = sel ? ready_b : ready_a;
  assign o_we    = sel ? we_b    : we_a;
  assign o_cpur  = sel ? cpur_b  : cpur_a;
  assign o_done  = sel ? done_b  : done_a;
  assign o_trunc = sel ? trunc_b : trunc_a;
  assign o_addr  = sel ? {7'b0, addr_b} : addr_a;
  assign o_wdata = sel ? wdata_b : wdata_a;
  assign o_count = sel ? {7'b0, count_b} : count_a;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Presents one word for a single edge, then withdraws it.
  task automatic applyStimulus(input logic [31:0] d, input logic l);
    valid = 1'b1;
    data  = d;
    last  = l;
    step();
    valid = 1'b0;
    last  = 1'b0;
  endtask

  task automatic pulseStart();
    startp = 1'b1;
    step();
    startp = 1'b0;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic checkWrite(input string tag, input logic [31:0] a, input logic [31:0] d);
    checkOutput({tag, "_we"},   {31'b0, o_we}, 32'd1);
    checkOutput({tag, "_addr"}, {22'b0, o_addr}, a);
    checkOutput({tag, "_data"}, o_wdata, d);
  endtask

  initial begin
    int gaps [3] = '{0, 2, 1};
    reset = 1'b1; startp = 1'b0; valid = 1'b0; last = 1'b0; sel = 1'b0; data = '0;

    // Reset values
    step(); step();
    checkOutput("rst_ready", {31'b0, o_ready}, 0);
    checkOutput("rst_we",    {31'b0, o_we}, 0);
    checkOutput("rst_addr",  {22'b0, o_addr}, 0);
    checkOutput("rst_wdata", o_wdata, 0);
    checkOutput("rst_cpur",  {31'b0, o_cpur}, 1);
    checkOutput("rst_done",  {31'b0, o_done}, 0);
    checkOutput("rst_count", {21'b0, o_count}, 0);
    checkOutput("rst_trunc", {31'b0, o_trunc}, 0);
    reset = 1'b0;
    step();
    checkOutput("ready_after_rst", {31'b0, o_ready}, 1);

    // Four back-to-back words, no padding
    for (int k = 0; k < 4; k++) begin
      applyStimulus(32'h11110000 + k, k == 3);
      checkWrite("t1_w", k, 32'h11110000 + k);
    end
    checkOutput("t1_ready_drop", {31'b0, o_ready}, 0);
    checkOutput("t1_cpur_w", {31'b0, o_cpur}, 1);
    step();
    checkOutput("t1_we_off", {31'b0, o_we}, 0);
    checkOutput("t1_cpur_h", {31'b0, o_cpur}, 1);
    step();
    checkOutput("t1_cpur_run", {31'b0, o_cpur}, 0);
    checkOutput("t1_done", {31'b0, o_done}, 1);
    checkOutput("t1_count", {21'b0, o_count}, 4);

    // Restart, then three words with idle gaps
    pulseStart();
    checkOutput("t2_cpur", {31'b0, o_cpur}, 1);
    checkOutput("t2_done", {31'b0, o_done}, 0);
    checkOutput("t2_count", {21'b0, o_count}, 0);
    checkOutput("t2_ready", {31'b0, o_ready}, 1);
    for (int k = 0; k < 3; k++) begin
      for (int g = 0; g < gaps[k]; g++) begin
        step();
        checkOutput("t2_idle_we", {31'b0, o_we}, 0);
        if (k > 0) checkOutput("t2_idle_addr", {22'b0, o_addr}, k - 1);
      end
      applyStimulus(32'hA0A00000 + k, k == 2);
      checkWrite("t2_w", k, 32'hA0A00000 + k);
    end
    step(); step();
    checkOutput("t2_done_run", {31'b0, o_done}, 1);
    checkOutput("t2_count_end", {21'b0, o_count}, 3);

    // Small memory, three words then NOP padding
    sel = 1'b1;
    #1;
    checkOutput("t3_ready", {31'b0, o_ready}, 1);
    for (int k = 0; k < 3; k++) begin
      applyStimulus(32'hB0B00000 + k, k == 2);
      checkWrite("t3_w", k, 32'hB0B00000 + k);
    end
    checkOutput("t3_ready_drop", {31'b0, o_ready}, 0);
    for (int j = 3; j < 8; j++) begin
      step();
      checkWrite("t3_fill", j, 32'h00000013);
      checkOutput("t3_fill_cpur", {31'b0, o_cpur}, 1);
    end
    step();
    checkOutput("t3_hold_we", {31'b0, o_we}, 0);
    checkOutput("t3_hold_done", {31'b0, o_done}, 0);
    step();
    checkOutput("t3_run_done", {31'b0, o_done}, 1);
    checkOutput("t3_run_cpur", {31'b0, o_cpur}, 0);
    checkOutput("t3_count", {21'b0, o_count}, 3);

    // Eight words without in_last: truncation
    pulseStart();
    for (int k = 0; k < 8; k++) begin
      applyStimulus(32'hC0C00000 + k, 1'b0);
      checkWrite("t4_w", k, 32'hC0C00000 + k);
    end
    checkOutput("t4_trunc", {31'b0, o_trunc}, 1);
    checkOutput("t4_count", {21'b0, o_count}, 8);
    checkOutput("t4_ready", {31'b0, o_ready}, 0);
    valid = 1'b1;
    data  = 32'hDEADBEEF;
    step();
    checkOutput("t4_extra_we", {31'b0, o_we}, 0);
    checkOutput("t4_extra_count", {21'b0, o_count}, 8);
    step();
    checkOutput("t4_run_done", {31'b0, o_done}, 1);
    checkOutput("t4_run_trunc", {31'b0, o_trunc}, 1);
    valid = 1'b0;

    // Restart from RUN with a two-word program
    pulseStart();
    checkOutput("t5_cpur", {31'b0, o_cpur}, 1);
    checkOutput("t5_done", {31'b0, o_done}, 0);
    checkOutput("t5_count", {21'b0, o_count}, 0);
    checkOutput("t5_trunc", {31'b0, o_trunc}, 0);
    applyStimulus(32'hE0E00000, 1'b0);
    checkWrite("t5_w0", 0, 32'hE0E00000);
    applyStimulus(32'hE0E00001, 1'b1);
    checkWrite("t5_w1", 1, 32'hE0E00001);
    for (int j = 2; j < 6; j++) begin
      step();
      checkWrite("t5_fill", j, 32'h00000013);
    end

    // Reset in the middle of padding (addr 5 just written)
    reset = 1'b1;
    step();
    checkOutput("t6_cpur", {31'b0, o_cpur}, 1);
    checkOutput("t6_we", {31'b0, o_we}, 0);
    checkOutput("t6_ready", {31'b0, o_ready}, 0);
    checkOutput("t6_count", {21'b0, o_count}, 0);
    checkOutput("t6_addr", {22'b0, o_addr}, 0);
    reset = 1'b0;
    step();
    checkOutput("t6_ready_up", {31'b0, o_ready}, 1);
    applyStimulus(32'hF0F00000, 1'b1);
    checkWrite("t6_w0", 0, 32'hF0F00000);
    checkOutput("t6_count1", {21'b0, o_count}, 1);
    for (int j = 1; j < 8; j++) begin
      step();
      checkWrite("t6_fill", j, 32'h00000013);
    end
    step();
    checkOutput("t6_hold_done", {31'b0, o_done}, 0);
    step();
    checkOutput("t6_run_done", {31'b0, o_done}, 1);
    checkOutput("t6_run_cpur", {31'b0, o_cpur}, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
